// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scans a 4x4 passive key matrix: drives one active-low row at a time,
// samples the pulled-up active-low columns, debounces whole frames and
// emits one event per new key press over a valid/ack handshake.
//
// Parameters:
//   DWELL    - clk cycles each row is held low per scan step (3..255)
//   DEBOUNCE - consecutive identical raw frames needed to accept (1..15)
//
// Ports:
//   clk       - system clock, posedge
//   rst       - asynchronous active-high reset
//   col_n     - column sense, active-low, asynchronous to clk
//   row_n     - row drive, active-low, one bit low when not in reset
//   key_ack   - consumer accepts the current event
//   key_valid - event pending
//   key_code  - pressed key index (row*4 + col), stable while key_valid
//   pressed   - debounced key state, bit row*4 + col
//
// Optional build macro:
//   KEYPAD_GHOST_REJECT_EN - suppress event loading on debounced frames
//   where two rows share two or more pressed columns (ghost rectangle).

module keypad_scanner #(
    parameter int unsigned DWELL    = 4,
    parameter int unsigned DEBOUNCE = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  col_n,
    output logic [3:0]  row_n,
    input  logic        key_ack,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [15:0] pressed
);

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
    localparam logic [3:0] CNT_MAX    = 4'(DEBOUNCE - 1);

    typedef enum logic {
        ST_IDLE,
        ST_SCAN
    } scan_state_t;

    scan_state_t state;
    logic [1:0]  row;
    logic [7:0]  dwell;
    logic [3:0]  col_s1;
    logic [3:0]  col_s2;
    logic [15:0] raw;
    logic [15:0] last_raw;
    logic [15:0] reported;
    logic [15:0] frame_raw;
    logic [15:0] cand;
    logic [3:0]  cnt;
    logic [3:0]  cnt_next;
    logic [3:0]  cand_idx;
    logic        capture;
    logic        frame_end;
    logic        accept;
    logic        ambiguous;
    logic        cand_any;
    logic        sel_pend;

`ifdef KEYPAD_GHOST_REJECT_EN
    // Two rows sharing two or more closed columns form a rectangle whose
    // fourth corner cannot be distinguished from a real press.
    function automatic logic ghost_pattern(input logic [15:0] f);
        logic [3:0] common;
        logic       hit;
        hit = 1'b0;
        for (int unsigned a = 0; a < 3; a++) begin
            for (int unsigned b = a + 1; b < 4; b++) begin
                common = f[a*4 +: 4] & f[b*4 +: 4];
                // more than one bit set <=> clearing the lowest leaves some
                if ((common & (common - 4'd1)) != 4'd0) begin
                    hit = 1'b1;
                end
            end
        end
        return hit;
    endfunction

    assign ambiguous = ghost_pattern(frame_raw);
`else
    assign ambiguous = 1'b0;
`endif

    // Row scan. The idle state gives one cycle after reset release so that
    // row 0 is driven for a full DWELL period before its first capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            row   <= '0;
            dwell <= '0;
            row_n <= '1;
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_SCAN;
                    row   <= '0;
                    dwell <= '0;
                    row_n <= 4'b1110;
                end
                ST_SCAN: begin
                    if (dwell == DWELL_LAST) begin
                        dwell <= '0;
                        row   <= row + 2'd1;
                        row_n <= ~(4'b0001 << (row + 2'd1));
                    end else begin
                        dwell <= dwell + 8'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Two-flop synchronizer; reset to the released (pulled-up) level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_s1 <= '1;
            col_s2 <= '1;
        end else begin
            col_s1 <= col_n;
            col_s2 <= col_s1;
        end
    end

    assign capture   = (state == ST_SCAN) && (dwell == DWELL_LAST);
    assign frame_end = capture && (row == 2'd3);

    // Frame as it will look once the current row's columns are merged in.
    always_comb begin
        frame_raw = raw;
        frame_raw[{row, 2'b00} +: 4] = ~col_s2;
    end

    always_comb begin
        cnt_next = '0;
        if (frame_raw == last_raw) begin
            cnt_next = (cnt >= CNT_MAX) ? CNT_MAX : cnt + 4'd1;
        end
    end

    assign accept = frame_end && (cnt_next == CNT_MAX);

    // Lowest-index candidate: scan downward so the lowest set bit wins.
    always_comb begin
        cand     = pressed & ~reported;
        cand_any = |cand;
        cand_idx = '0;
        for (int unsigned i = 16; i > 0; i--) begin
            if (cand[i-1]) begin
                cand_idx = 4'(i - 1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raw       <= '0;
            last_raw  <= '0;
            cnt       <= '0;
            pressed   <= '0;
            reported  <= '0;
            sel_pend  <= 1'b0;
            key_valid <= 1'b0;
            key_code  <= '0;
        end else begin
            if (capture) begin
                raw <= frame_raw;
            end
            if (frame_end) begin
                last_raw <= frame_raw;
                cnt      <= cnt_next;
            end

            // Selection runs one cycle after a pressed update so it sees the
            // freshly masked reported set.
            sel_pend <= accept && !ambiguous;
            if (accept) begin
                pressed <= frame_raw;
                if (!ambiguous) begin
                    reported <= reported & frame_raw;
                end
            end

            if (key_valid && key_ack) begin
                key_valid <= 1'b0;
            end else if (sel_pend && !key_valid && cand_any) begin
                key_valid          <= 1'b1;
                key_code           <= cand_idx;
                reported[cand_idx] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
// Directed bench for keypad_scanner with an ideal key-matrix model and a
// frame-level reference model compared against the DUT every cycle.
// Honours KEYPAD_GHOST_REJECT_EN the same way as the design.

module tb_keypad_scanner;

    localparam int unsigned DWELL    = 4;
    localparam int unsigned DEBOUNCE = 3;
    localparam int          FRAME    = 4 * DWELL;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        key_ack = 1'b0;
    logic [15:0] keys    = '0;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] pressed;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Ideal matrix: a driven row pulls down the columns of its closed keys.
    always_comb begin
        logic [3:0] low;
        low = 4'b0000;
        for (int r = 0; r < 4; r++) begin
            if (!row_n[r]) low = low | keys[r*4 +: 4];
        end
        col_n = ~low;
    end

    keypad_scanner #(
        .DWELL   (DWELL),
        .DEBOUNCE(DEBOUNCE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .col_n    (col_n),
        .row_n    (row_n),
        .key_ack  (key_ack),
        .key_valid(key_valid),
        .key_code (key_code),
        .pressed  (pressed)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

`ifdef KEYPAD_GHOST_REJECT_EN
    function automatic bit is_ghost(input logic [15:0] f);
        for (int a = 0; a < 4; a++)
            for (int b = a + 1; b < 4; b++)
                if ($countones(f[a*4 +: 4] & f[b*4 +: 4]) >= 2) return 1'b1;
        return 1'b0;
    endfunction
`endif

    // Reference model state. Time base: e_cnt = edges since reset release;
    // after edge e the row in drive is ((e-1)/DWELL)%4, and the edge ending
    // scan cycle n = e-2 captures when n%DWELL == DWELL-1, using the key
    // state seen two edges earlier (synchronizer depth).
    int unsigned  e_cnt = 0;
    logic [15:0]  kh1 = '0, kh2 = '0, acc = '0;
    logic [15:0]  m_pressed = '0, m_reported = '0, m_cand;
    logic         m_valid = 1'b0, m_sel = 1'b0, m_v0, m_same, m_amb;
    logic [3:0]   m_code = '0;
    logic [15:0]  hist[$];
    int unsigned  m_n, m_r;

    initial begin
        hist.push_back(16'h0000);
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                e_cnt = 0; kh1 = '0; kh2 = '0; acc = '0;
                m_pressed = '0; m_reported = '0; m_valid = 1'b0;
                m_sel = 1'b0; m_code = '0;
                hist.delete();
                hist.push_back(16'h0000);
            end else begin
                m_v0 = m_valid;
                if (m_v0 && key_ack) m_valid = 1'b0;
                if (m_sel && !m_v0) begin
                    m_cand = m_pressed & ~m_reported;
                    if (m_cand != 0) begin
                        for (int i = 15; i >= 0; i--) if (m_cand[i]) m_code = 4'(i);
                        m_valid = 1'b1;
                        m_reported[m_code] = 1'b1;
                    end
                end
                m_sel = 1'b0;
                e_cnt++;
                if (e_cnt >= 2) begin
                    m_n = e_cnt - 2;
                    if (m_n % DWELL == DWELL - 1) begin
                        m_r = (m_n / DWELL) % 4;
                        acc[m_r*4 +: 4] = kh2[m_r*4 +: 4];
                        if (m_r == 3) begin
                            hist.push_back(acc);
                            if (hist.size() > DEBOUNCE) void'(hist.pop_front());
                            m_same = (hist.size() == DEBOUNCE);
                            foreach (hist[i]) if (hist[i] != acc) m_same = 1'b0;
                            if (m_same) begin
                                m_pressed = acc;
`ifdef KEYPAD_GHOST_REJECT_EN
                                m_amb = is_ghost(acc);
`else
                                m_amb = 1'b0;
`endif
                                if (!m_amb) begin
                                    m_reported = m_reported & acc;
                                    m_sel = 1'b1;
                                end
                            end
                        end
                    end
                end
                kh2 = kh1;
                kh1 = keys;
            end
        end
    end

    // Per-cycle comparison against the model.
    logic [3:0] exp_row;
    initial begin
        forever begin
            @(negedge clk);
            exp_row = 4'hF;
            if (!rst && e_cnt != 0) exp_row[((e_cnt - 1) / DWELL) % 4] = 1'b0;
            chk("row_n", 32'(row_n), 32'(exp_row));
            chk("key_valid", 32'(key_valid), 32'(m_valid));
            chk("key_code", 32'(key_code), 32'(m_code));
            chk("pressed", 32'(pressed), 32'(m_pressed));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input string name, input int bound);
        int w;
        w = 0;
        while (!key_valid && w < bound) begin
            @(negedge clk);
            w++;
        end
        chk({name, "_valid_in_time"}, 32'(key_valid), 32'd1);
    endtask

    task automatic do_ack(input string name);
        key_ack = 1'b1;
        @(negedge clk);
        key_ack = 1'b0;
        chk({name, "_ack_clears"}, 32'(key_valid), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cycles(3);
        chk("rst_row_n", 32'(row_n), 32'hF);
        chk("rst_valid", 32'(key_valid), 32'd0);
        chk("rst_code", 32'(key_code), 32'd0);
        chk("rst_pressed", 32'(pressed), 32'd0);
        rst = 1'b0;
        cycles(4 * FRAME);

        // stray ack while idle is ignored
        key_ack = 1'b1;
        cycles(1);
        key_ack = 1'b0;
        cycles(FRAME);

        // single press, key 9 (row 2, col 1)
        keys = 16'h0200;
        wait_valid("single", 67);
        chk("single_code", 32'(key_code), 32'd9);
        chk("single_pressed", 32'(pressed), 32'h0200);
        do_ack("single");
        cycles(5 * FRAME);
        chk("single_no_repeat", 32'(key_valid), 32'd0);
        keys = '0;
        cycles(5 * FRAME);
        chk("single_released", 32'(pressed), 32'h0000);

        // bounce on key 5: alternate frames never agree
        for (int i = 0; i < 10; i++) begin
            keys = (i % 2 == 0) ? 16'h0020 : 16'h0000;
            cycles(FRAME);
        end
        keys = '0;
        cycles(5 * FRAME);
        chk("bounce_no_valid", 32'(key_valid), 32'd0);
        chk("bounce_pressed", 32'(pressed), 32'h0000);
        keys = 16'h0020;
        wait_valid("bounce_hold", 67);
        chk("bounce_code", 32'(key_code), 32'd5);
        do_ack("bounce");
        cycles(4 * FRAME);
        chk("bounce_once", 32'(key_valid), 32'd0);
        keys = '0;
        cycles(5 * FRAME);

        // simultaneous keys 3 and 12
        keys = 16'h1008;
        wait_valid("simul1", 80);
        chk("simul1_code", 32'(key_code), 32'd3);
        chk("simul_pressed", 32'(pressed), 32'h1008);
        do_ack("simul1");
        wait_valid("simul2", 2 * FRAME + 4);
        chk("simul2_code", 32'(key_code), 32'd12);
        do_ack("simul2");
        keys = '0;
        cycles(5 * FRAME);

        // no ack, release, repress key 0
        keys = 16'h0001;
        wait_valid("noack", 67);
        chk("noack_code", 32'(key_code), 32'd0);
        keys = '0;
        cycles(5 * FRAME);
        chk("noack_rel_valid", 32'(key_valid), 32'd1);
        chk("noack_rel_code", 32'(key_code), 32'd0);
        chk("noack_rel_pressed", 32'(pressed), 32'h0000);
        keys = 16'h0001;
        cycles(5 * FRAME);
        chk("noack_rep_valid", 32'(key_valid), 32'd1);
        chk("noack_rep_pressed", 32'(pressed), 32'h0001);
        do_ack("noack1");
        wait_valid("noack_again", 2 * FRAME + 4);
        chk("noack_again_code", 32'(key_code), 32'd0);
        do_ack("noack2");
        cycles(4 * FRAME);
        chk("noack_done", 32'(key_valid), 32'd0);
        keys = '0;
        cycles(5 * FRAME);

        // reset while an event is pending
        keys = 16'h0400;
        wait_valid("rstmid", 67);
        chk("rstmid_code", 32'(key_code), 32'd10);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_valid", 32'(key_valid), 32'd0);
        chk("rstmid_row_n", 32'(row_n), 32'hF);
        chk("rstmid_pressed", 32'(pressed), 32'h0000);
        keys = '0;
        cycles(2);
        rst = 1'b0;
        for (int i = 0; i < int'(DWELL); i++) begin
            @(posedge clk);
            #1;
            chk("rstrel_row0", 32'(row_n), 32'hE);
        end
        @(posedge clk);
        #1;
        chk("rstrel_row1", 32'(row_n), 32'hD);
        cycles(5 * FRAME);

`ifdef KEYPAD_GHOST_REJECT_EN
        // keys 0,1,4 then add 5 (rectangle), then release 0
        keys = 16'h0013;
        wait_valid("ghost_a", 80);
        chk("ghost_a_code", 32'(key_code), 32'd0);
        do_ack("ghost_a");
        wait_valid("ghost_b", 2 * FRAME + 4);
        chk("ghost_b_code", 32'(key_code), 32'd1);
        do_ack("ghost_b");
        wait_valid("ghost_c", 2 * FRAME + 4);
        chk("ghost_c_code", 32'(key_code), 32'd4);
        do_ack("ghost_c");
        keys = 16'h0033;
        cycles(6 * FRAME);
        chk("ghost_blocked", 32'(key_valid), 32'd0);
        chk("ghost_pressed", 32'(pressed), 32'h0033);
        keys = 16'h0032;
        wait_valid("ghost_d", 80);
        chk("ghost_d_code", 32'(key_code), 32'd5);
        do_ack("ghost_d");
        keys = '0;
        cycles(5 * FRAME);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Reads a 4x4 passive key matrix by scanning rows and sensing columns. It is the input-side counterpart of the row-scanned LED matrix driver.
- Drives one active-low row at a time and samples the active-low columns, which have pull-ups.
- Debounces whole frames and emits one key-press event per new press over a valid/ack handshake.
- Sits beside the clock/display logic so the user can set the time from a keypad.

Parameters:
- DWELL, 4, clk cycles each row is held low per scan step; legal range 3..255.
- DEBOUNCE, 3, consecutive identical raw frames required before the debounced state updates; legal range 1..15.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  reset, asynchronous, active-high.
- col_n  input  4  column sense, active-low (0 = key closed on the driven row); asynchronous to clk.
- row_n  output  4  row drive, active-low, exactly one bit low when not in reset.
- key_ack  input  1  consumer accepts the current event.
- key_valid  output  1  event pending.
- key_code  output  4  index of the pressed key = row*4 + col; held stable while key_valid=1.
- pressed  output  16  debounced key state, bit row*4+col.

Behaviour:
- Reset (async assert, sync release): row_n=4'b1111, key_valid=0, key_code=0, pressed=0. Row counter, dwell counter, raw frame, last frame, debounce count and reported mask are all cleared.
- Reset mid-operation: the frame in progress is discarded and any pending event is lost. The first scan after release starts at row 0.
- Scan:
  - row_n=~(1<<row). Row advances 0,1,2,3,0 every DWELL cycles, so one frame is 4*DWELL cycles.
  - col_n passes through a 2-flop synchronizer.
  - raw[row*4+c] = ~col_sync[c], captured on the last dwell cycle of each row. This gives at least 2 cycles of settle after the row switch.
- Frame end (the cycle row 3 is captured):
  - If raw == last_raw, cnt = min(cnt+1, DEBOUNCE-1); otherwise cnt=0. Then last_raw <= raw.
  - If the new cnt == DEBOUNCE-1, pressed <= raw. With DEBOUNCE=1, every frame is accepted.
- Reported mask:
  - On every pressed update, reported <= reported & pressed. A released key may therefore report again on its next press.
- Event selection, in the cycle after a pressed update:
  - cand = pressed & ~reported.
  - If cand != 0 and key_valid=0: key_code <= index of the lowest set bit of cand, key_valid <= 1, and that reported bit is set.
  - At most one event loads per frame. Remaining candidates wait for later frames, so multiple simultaneous presses are never lost.
- Handshake:
  - key_valid stays high until key_ack=1 is sampled with key_valid=1; key_valid falls on the next edge.
  - key_ack while key_valid=0 is ignored.
  - An ack landing on the same cycle as an event load cannot occur, because a load requires key_valid=0.
  - A new event can load at the earliest at the next frame's selection cycle.
- Held key: reports once and never auto-repeats. Releasing the key while its event is pending does not cancel the event.
- Latency (DWELL=4, DEBOUNCE=3): key_valid rises at most (DEBOUNCE+1)*4*DWELL+3 = 67 cycles after col_n becomes stable.
- Widths: dwell counter 8 bits, row counter 2 bits wrapping, cnt 4 bits saturating.

Optional Feature:
- Macro: KEYPAD_GHOST_REJECT_EN.
- Defined: a debounced frame is ambiguous when any two rows have two or more pressed columns in common (the rectangle ghosting pattern).
  - In an ambiguous frame, pressed still updates but no new events load and reported does not change.
  - Event loading resumes on the first non-ambiguous frame.
- Undefined: no ghost check; every candidate is reported.

Test Plan:
- Single press: hold col_n[1]=0 only while row_n[2]=0 (key 9) -> key_valid=1 within 67 cycles, key_code=9, pressed=16'h0200. Ack -> key_valid=0, with no repeat while the key is held.
- Bounce: toggle key 5 on alternate frames for 10 frames, then hold it released -> no key_valid and pressed stays 0. Then hold it pressed -> exactly one event, code 5.
- Simultaneous: press keys 3 and 12 in the same frame -> event code 3. Ack, then a second event, code 12, appears at a later frame.
- No ack, release, repress: press key 0 without acking, release, repress -> key_valid stays 1 with code 0 throughout. After ack, one further event with code 0 appears.
- Reset mid-event: assert rst while key_valid=1 -> key_valid=0, row_n=4'b1111 immediately, pressed=0. After release, row_n=4'b1110 for the first DWELL cycles.
- Ghost (macro defined): press keys 0, 1 and 4, then add 5 -> events for 0, 1, 4. No event for 5 while all four are held. Releasing key 0 lets code 5 report.
